// File: rtl/fft_stage02_pkg.sv
// fft_stage02_pkg: shared constants, types and elaboration-time helpers for
// the stage-02 twiddle sequencer of the 512-point, 16-path FFT.
//   tw_exp(b, p)   : twiddle exponent for block b, path p.
//   tw_cos_sin(e)  : rounded Q1.7 twiddle pair for exponent e (elaboration only).
package fft_stage02_pkg;

   localparam int unsigned N_POINT          = 512;
   localparam int unsigned TW_SPAN          = 64;
   localparam int unsigned NUM_PATHS        = 16;
   localparam int unsigned BLOCKS_PER_FRAME = N_POINT / NUM_PATHS;
   localparam int unsigned BLK_W            = $clog2(BLOCKS_PER_FRAME);

   typedef logic signed [8:0] tw_t;

   typedef struct packed {
      tw_t re;
      tw_t im;
   } tw_pair_t;

   // Fixed-point scale used by the elaboration-time sine/cosine series.
   localparam longint TRIG_S = 64'sd268435456;  // 2^28
   localparam longint PI_S   = 64'sd843314857;  // round(pi * 2^28)

   function automatic int unsigned tw_exp(input int unsigned b, input int unsigned p);
      int unsigned n;
      n = b * NUM_PATHS + p;
      return ((n % TW_SPAN) * (n / TW_SPAN)) % N_POINT;
   endfunction

   // Returns (round(128*cos(2*pi*e/N)), round(-128*sin(2*pi*e/N))), half away
   // from zero. The angle is folded into the first quadrant so the Taylor
   // series only ever sees phi in [0, pi/2) and both results are non-negative
   // before the quadrant signs are applied.
   function automatic tw_pair_t tw_cos_sin(input int unsigned e);
      int unsigned q;
      int unsigned k;
      longint      x;
      longint      term_s;
      longint      term_c;
      longint      sum_s;
      longint      sum_c;
      longint      s;
      longint      c;
      tw_pair_t    pr;
      q      = (e % N_POINT) / (N_POINT / 4);
      k      = e % (N_POINT / 4);
      x      = (longint'(k) * PI_S) / longint'(N_POINT / 2);
      term_s = x;
      sum_s  = x;
      term_c = TRIG_S;
      sum_c  = TRIG_S;
      for (int i = 1; i <= 12; i++) begin
         term_s = -(((term_s * x) / TRIG_S) * x) / (TRIG_S * longint'((2 * i) * (2 * i + 1)));
         term_c = -(((term_c * x) / TRIG_S) * x) / (TRIG_S * longint'((2 * i - 1) * (2 * i)));
         sum_s  = sum_s + term_s;
         sum_c  = sum_c + term_c;
      end
      s = (128 * sum_s + TRIG_S / 2) / TRIG_S;
      c = (128 * sum_c + TRIG_S / 2) / TRIG_S;
      case (q)
         0:       begin pr.re = tw_t'(c);  pr.im = tw_t'(-s); end
         1:       begin pr.re = tw_t'(-s); pr.im = tw_t'(-c); end
         2:       begin pr.re = tw_t'(-c); pr.im = tw_t'(s);  end
         default: begin pr.re = tw_t'(s);  pr.im = tw_t'(c);  end
      endcase
      return pr;
   endfunction

endpackage

// File: rtl/tw_rom_path.sv
// tw_rom_path: constant 32-entry twiddle table for one datapath lane, with a
// registered output.
//   clk, rst : clock, synchronous active-high reset (clears outputs)
//   en       : load a new entry this cycle; outputs hold otherwise
//   addr     : block index b
//   re, im   : registered twiddle pair for (b, PATH_IDX)
module tw_rom_path
   import fft_stage02_pkg::*;
#(
   parameter int unsigned PATH_IDX = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [BLK_W-1:0] addr,
   output tw_t              re,
   output tw_t              im
);

   tw_pair_t rom [BLOCKS_PER_FRAME];

   for (genvar i = 0; i < BLOCKS_PER_FRAME; i++) begin : g_entry
      localparam tw_pair_t ENTRY = tw_cos_sin(tw_exp(i, PATH_IDX));
      assign rom[i] = ENTRY;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         re <= '0;
         im <= '0;
      end else if (en) begin
         re <= rom[addr].re;
         im <= rom[addr].im;
      end
   end

endmodule

// File: rtl/twiddle_seq_02.sv
// twiddle_seq_02: stage-02 twiddle sequencer. Counts beats within a frame and
// presents each beat's butterfly data together with its 16 twiddles one cycle
// later, aligned for the stage-02 complex multiplier.
//   clk, rst            : clock, synchronous active-high reset
//   din_valid           : butterfly beat present
//   frame_start         : current valid beat is block 0
//   bfly_re, bfly_im    : per-path butterfly samples
//   bfly_re_d, bfly_im_d: samples delayed one cycle
//   tw_re, tw_im        : per-path twiddles (Q1.7)
//   tw_valid            : outputs carry a beat
//   blk_idx             : block index of the output beat
//   frame_done          : pulse with the output beat of the last block
module twiddle_seq_02
   import fft_stage02_pkg::*;
#(
   parameter int unsigned NUM_PARALLEL_PATHS = 16,
   parameter int unsigned DATA_IN_WIDTH      = 13,
   parameter int unsigned TW_WIDTH           = 9
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            din_valid,
   input  logic                            frame_start,
   input  logic signed [DATA_IN_WIDTH-1:0] bfly_re   [NUM_PARALLEL_PATHS],
   input  logic signed [DATA_IN_WIDTH-1:0] bfly_im   [NUM_PARALLEL_PATHS],
   output logic signed [DATA_IN_WIDTH-1:0] bfly_re_d [NUM_PARALLEL_PATHS],
   output logic signed [DATA_IN_WIDTH-1:0] bfly_im_d [NUM_PARALLEL_PATHS],
   output logic signed [TW_WIDTH-1:0]      tw_re     [NUM_PARALLEL_PATHS],
   output logic signed [TW_WIDTH-1:0]      tw_im     [NUM_PARALLEL_PATHS],
   output logic                            tw_valid,
   output logic [BLK_W-1:0]                blk_idx,
   output logic                            frame_done
);

   logic [BLK_W-1:0] cnt_q;
   logic [BLK_W-1:0] blk_b;

   // frame_start only matters on a valid beat; it forces that beat to block 0.
   assign blk_b = frame_start ? '0 : cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         tw_valid   <= 1'b0;
         frame_done <= 1'b0;
         blk_idx    <= '0;
         for (int p = 0; p < NUM_PARALLEL_PATHS; p++) begin
            bfly_re_d[p] <= '0;
            bfly_im_d[p] <= '0;
         end
      end else if (din_valid) begin
         cnt_q      <= blk_b + 1'b1;  // natural 5-bit wrap after the last block
         tw_valid   <= 1'b1;
         frame_done <= (blk_b == BLK_W'(BLOCKS_PER_FRAME - 1));
         blk_idx    <= blk_b;
         for (int p = 0; p < NUM_PARALLEL_PATHS; p++) begin
            bfly_re_d[p] <= bfly_re[p];
            bfly_im_d[p] <= bfly_im[p];
         end
      end else begin
         // Data and twiddles hold; consumers qualify them with tw_valid.
         tw_valid   <= 1'b0;
         frame_done <= 1'b0;
      end
   end

   for (genvar p = 0; p < NUM_PARALLEL_PATHS; p++) begin : g_path
      tw_rom_path #(
         .PATH_IDX (p)
      ) u_rom (
         .clk  (clk),
         .rst  (rst),
         .en   (din_valid),
         .addr (blk_b),
         .re   (tw_re[p]),
         .im   (tw_im[p])
      );
   end

endmodule

// File: tb/tb_twiddle_seq_02.sv
module tb_twiddle_seq_02;

   localparam int P   = 16;
   localparam int DW  = 13;
   localparam int TWW = 9;
   localparam real PI = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din_valid = 1'b0;
   logic frame_start = 1'b0;
   logic signed [DW-1:0]  bfly_re   [P];
   logic signed [DW-1:0]  bfly_im   [P];
   logic signed [DW-1:0]  bfly_re_d [P];
   logic signed [DW-1:0]  bfly_im_d [P];
   logic signed [TWW-1:0] tw_re     [P];
   logic signed [TWW-1:0] tw_im     [P];
   logic                  tw_valid;
   logic [4:0]            blk_idx;
   logic                  frame_done;

   typedef struct {
      logic [P-1:0][DW-1:0]  re;
      logic [P-1:0][DW-1:0]  im;
      logic [P-1:0][TWW-1:0] twr;
      logic [P-1:0][TWW-1:0] twi;
      int                    blk;
      bit                    done;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   model_cnt = 0;
   bit   mon_en = 1'b0;

   twiddle_seq_02 dut (
      .clk         (clk),
      .rst         (rst),
      .din_valid   (din_valid),
      .frame_start (frame_start),
      .bfly_re     (bfly_re),
      .bfly_im     (bfly_im),
      .bfly_re_d   (bfly_re_d),
      .bfly_im_d   (bfly_im_d),
      .tw_re       (tw_re),
      .tw_im       (tw_im),
      .tw_valid    (tw_valid),
      .blk_idx     (blk_idx),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   function automatic int rnd_away(input real r);
      if (r >= 0.0) return $rtoi($floor(r + 0.5));
      return -$rtoi($floor(-r + 0.5));
   endfunction

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // One cycle of stimulus; valid beats get their expected response queued.
   task automatic step(input bit v, input bit fs);
      exp_t x;
      int   b;
      int   n;
      int   e;
      real  ang;
      @(negedge clk);
      din_valid   = v;
      frame_start = fs;
      for (int p = 0; p < P; p++) begin
         bfly_re[p] = DW'($urandom);
         bfly_im[p] = DW'($urandom);
      end
      if (v && !rst) begin
         b         = fs ? 0 : model_cnt;
         model_cnt = (b + 1) % 32;
         x.blk     = b;
         x.done    = (b == 31);
         for (int p = 0; p < P; p++) begin
            x.re[p]  = bfly_re[p];
            x.im[p]  = bfly_im[p];
            n        = b * 16 + p;
            e        = ((n % 64) * (n / 64)) % 512;
            ang      = 2.0 * PI * real'(e) / 512.0;
            x.twr[p] = TWW'(rnd_away(128.0 * $cos(ang)));
            x.twi[p] = TWW'(rnd_away(-128.0 * $sin(ang)));
         end
         sb.push_back(x);
      end
   endtask

   // Reset lands on a valid beat; that beat must vanish.
   task automatic reset_on_beat();
      @(negedge clk);
      rst         = 1'b1;
      din_valid   = 1'b1;
      frame_start = 1'b0;
      model_cnt   = 0;
      @(negedge clk);
      rst       = 1'b0;
      din_valid = 1'b0;
      chk("tw_valid_after_rst", tw_valid, 0);
   endtask

   initial begin : monitor
      exp_t x;
      bit   ok;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (tw_valid === 1'b1) begin
               if (sb.size() == 0) begin
                  chk("unexpected_beat", 1, 0);
               end else begin
                  x  = sb.pop_front();
                  ok = 1'b1;
                  for (int p = 0; p < P; p++) begin
                     if (ok && (bfly_re_d[p] !== x.re[p] || bfly_im_d[p] !== x.im[p])) begin
                        $display("FAIL data p%0d: got (%0d,%0d), expected (%0d,%0d)", p,
                                 bfly_re_d[p], bfly_im_d[p], $signed(x.re[p]), $signed(x.im[p]));
                        ok = 1'b0;
                     end
                  end
                  n_checks++;
                  if (!ok) n_fail++;
                  ok = 1'b1;
                  for (int p = 0; p < P; p++) begin
                     if (ok && (tw_re[p] !== x.twr[p] || tw_im[p] !== x.twi[p])) begin
                        $display("FAIL twiddle blk %0d p%0d: got (%0d,%0d), expected (%0d,%0d)",
                                 x.blk, p, tw_re[p], tw_im[p], $signed(x.twr[p]),
                                 $signed(x.twi[p]));
                        ok = 1'b0;
                     end
                  end
                  n_checks++;
                  if (!ok) n_fail++;
                  chk("blk_idx", blk_idx, x.blk);
                  chk("frame_done", frame_done, x.done);
               end
            end else begin
               chk("idle_valid_done", {tw_valid, frame_done}, 0);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      for (int p = 0; p < P; p++) begin
         bfly_re[p] = '0;
         bfly_im[p] = '0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_tw_valid", tw_valid, 0);
      chk("reset_blk_idx", blk_idx, 0);
      chk("reset_tw_re0", tw_re[0], 0);
      mon_en = 1'b1;

      // Frame 0 with directed spot checks.
      step(1, 1);
      step(0, 0);
      chk("beat0_tw_valid", tw_valid, 1);
      chk("beat0_blk_idx", blk_idx, 0);
      for (int p = 0; p < P; p++) begin
         chk("beat0_tw_re", tw_re[p], 128);
         chk("beat0_tw_im", tw_im[p], 0);
      end
      for (int i = 1; i <= 4; i++) step(1, 0);
      step(0, 0);
      chk("beat4_p1_re", tw_re[1], 128);
      chk("beat4_p1_im", tw_im[1], -2);
      chk("beat4_p15_re", tw_re[15], 126);
      chk("beat4_p15_im", tw_im[15], -23);
      for (int i = 5; i <= 31; i++) step(1, 0);
      step(0, 0);
      chk("beat31_frame_done", frame_done, 1);
      chk("beat31_blk_idx", blk_idx, 31);
      chk("beat31_p0_re", tw_re[0], -71);
      chk("beat31_p0_im", tw_im[0], 106);
      step(0, 0);
      chk("frame_done_pulse_end", frame_done, 0);
      step(1, 0);
      step(0, 0);
      chk("wrap_blk_idx", blk_idx, 0);

      // Gapped frame; idle cycles carry stray frame_start.
      for (int i = 0; i < 32; i++) begin
         step(1, i == 0);
         repeat ($urandom_range(0, 3)) step(0, 1'($urandom_range(0, 1)));
      end

      // Mid-frame restart at beat 10.
      for (int i = 0; i < 10; i++) step(1, i == 0);
      step(1, 1);
      step(0, 0);
      chk("restart_blk_idx", blk_idx, 0);
      for (int i = 0; i < 40; i++) step(1, 0);

      // Reset on a valid beat at block 12.
      for (int i = 0; i < 12; i++) step(1, i == 0);
      reset_on_beat();
      step(1, 0);
      step(0, 0);
      chk("post_rst_blk_idx", blk_idx, 0);

      // Free-running random traffic.
      for (int i = 0; i < 300; i++) step(($urandom % 4) != 0, ($urandom % 40) == 0);

      repeat (3) step(0, 0);
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
